// File: rtl/demux_data.sv
// rtl/demux_data.sv - receive-side byte reassembler for the two-channel ADC link
//
// Rebuilds two 2*Width-bit channel samples from the byte sequence
// ch0 MSB, ch0 LSB, ch1 MSB, ch1 LSB and flags each completed frame with a
// one-cycle valid_o pulse. An inter-byte timeout inside a frame discards the
// partial frame, pulses err_o and returns to waiting for a frame start.
//
// Ports:
//   clk_i     in   1         system clock, rising edge
//   rst_ni    in   1         asynchronous active-low reset
//   din_i     in   Width     received byte, sampled when dvalid_i=1
//   dvalid_i  in   1         one-cycle byte strobe
//   ch0_o     out  2*Width   last complete ch0 sample {MSB, LSB}
//   ch1_o     out  2*Width   last complete ch1 sample {MSB, LSB}
//   valid_o   out  1         one-cycle pulse: ch0_o/ch1_o hold a new frame
//   sel_o     out  2         next expected byte slot (00 MCH0 .. 11 LCH1)
//   err_o     out  1         one-cycle pulse: partial frame dropped on timeout

module demux_data #(
    parameter int Width         = 8,
    parameter int TimeoutCycles = 100000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [Width-1:0]     din_i,
    input  logic                 dvalid_i,
    output logic [2*Width-1:0]   ch0_o,
    output logic [2*Width-1:0]   ch1_o,
    output logic                 valid_o,
    output logic [1:0]           sel_o,
    output logic                 err_o
);

    localparam int              CntW    = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    // State encoding doubles as the sel_o slot index.
    typedef enum logic [1:0] {
        S_MCH0 = 2'b00,
        S_LCH0 = 2'b01,
        S_MCH1 = 2'b10,
        S_LCH1 = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CntW-1:0]      r_cnt;
    logic [Width-1:0]     r_sh_mch0;
    logic [Width-1:0]     r_sh_lch0;
    logic [Width-1:0]     r_sh_mch1;
    logic [2*Width-1:0]   r_ch0;
    logic [2*Width-1:0]   r_ch1;
    logic                 r_valid;
    logic                 r_err;

    logic                 w_expire;
    logic                 w_frame_done;

    // A byte arriving on the expiry cycle wins: expiry requires dvalid_i=0.
    // The counter only runs inside a frame, so an idle line never expires.
    assign w_expire     = (r_state != S_MCH0) && !dvalid_i && (r_cnt == CntLast);
    assign w_frame_done = dvalid_i && (r_state == S_LCH1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_MCH0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (dvalid_i) begin
            case (r_state)
                S_MCH0:  w_state_next = S_LCH0;
                S_LCH0:  w_state_next = S_MCH1;
                S_MCH1:  w_state_next = S_LCH1;
                S_LCH1:  w_state_next = S_MCH0;
                default: w_state_next = S_MCH0;
            endcase
        end else if (w_expire) begin
            w_state_next = S_MCH0;
        end
    end

    // ---------------- inter-byte timeout counter ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if ((r_state == S_MCH0) || dvalid_i || w_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ---------------- shadow registers for the partial frame ----------------
    // Not cleared on timeout; the next frame overwrites every slot before use.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sh_mch0 <= '0;
            r_sh_lch0 <= '0;
            r_sh_mch1 <= '0;
        end else if (dvalid_i) begin
            case (r_state)
                S_MCH0:  r_sh_mch0 <= din_i;
                S_LCH0:  r_sh_lch0 <= din_i;
                S_MCH1:  r_sh_mch1 <= din_i;
                default: ;
            endcase
        end
    end

    // ---------------- output registers ----------------
    // The final LSB goes straight from din_i into ch1 so the frame is
    // published on the same edge that accepts its last byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ch0   <= '0;
            r_ch1   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_frame_done;
            r_err   <= w_expire;
            if (w_frame_done) begin
                r_ch0 <= {r_sh_mch0, r_sh_lch0};
                r_ch1 <= {r_sh_mch1, din_i};
            end
        end
    end

    assign ch0_o   = r_ch0;
    assign ch1_o   = r_ch1;
    assign valid_o = r_valid;
    assign err_o   = r_err;
    assign sel_o   = r_state;

endmodule
